// File: rtl/regfile_writeback.sv
// Write-side controller for the register file: merges non-stallable ALU
// results and handshaked load results onto one registered write port.
// Loads wait in a small circular FIFO. A younger ALU write squashes older
// pending loads to the same register. Writes to register 0 are dropped.
//
// Ports:
//   clk, rst (async active-low)
//   alu_valid/alu_rd/alu_data            ALU result, every cycle, no stall
//   ld_valid/ld_ready/ld_rd/ld_data      load result handshake
//   rs, rt -> hazard_rs, hazard_rt       read hazards vs. pending writes
//   stall_req                            load FIFO full
//   wr_en/rd/out                         registered register-file write port
//   pend_cnt                             number of valid FIFO entries
module regfile_writeback #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [ADDR_W-1:0]            alu_rd,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [ADDR_W-1:0]            ld_rd,
    input  logic [DATA_W-1:0]            ld_data,
    input  logic [ADDR_W-1:0]            rs,
    input  logic [ADDR_W-1:0]            rt,
    output logic                         hazard_rs,
    output logic                         hazard_rt,
    output logic                         stall_req,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            rd,
    output logic [DATA_W-1:0]            out,
    output logic [$clog2(DEPTH):0]       pend_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ent_rd_q   [DEPTH];
    logic [ADDR_W-1:0] ent_rd_d   [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] out_q, out_d;

    // Entries in age order (index 0 = head) and the compacted next list
    logic [ADDR_W-1:0] ord_rd   [DEPTH];
    logic [DATA_W-1:0] ord_data [DEPTH];
    logic [DEPTH-1:0]  ord_v;
    logic [ADDR_W-1:0] new_rd   [DEPTH];
    logic [DATA_W-1:0] new_data [DEPTH];
    logic [CNT_W-1:0]  new_cnt;
    logic [PTR_W-1:0]  rd_idx, wr_idx;
    logic              alu_eff, ld_eff, drain, bypass, enq;

    assign ld_ready  = (cnt_q < CNT_W'(DEPTH));
    assign stall_req = (cnt_q == CNT_W'(DEPTH));
    assign pend_cnt  = cnt_q;
    assign wr_en     = wr_en_q;
    assign rd        = rd_q;
    assign out       = out_q;

    // Read hazards against pending FIFO entries and the write in flight
    always_comb begin
        hazard_rs = 1'b0;
        hazard_rt = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (valid_q[k] && ent_rd_q[k] == rs) hazard_rs = 1'b1;
            if (valid_q[k] && ent_rd_q[k] == rt) hazard_rt = 1'b1;
        end
        if (wr_en_q && rd_q == rs) hazard_rs = 1'b1;
        if (wr_en_q && rd_q == rt) hazard_rt = 1'b1;
        if (rs == '0) hazard_rs = 1'b0;
        if (rt == '0) hazard_rt = 1'b0;
    end

    // Arbitration, squash/compaction and FIFO next state
    always_comb begin
        wr_en_d    = 1'b0;
        rd_d       = rd_q;
        out_d      = out_q;
        drain      = 1'b0;
        bypass     = 1'b0;
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        valid_d    = '0;
        new_cnt    = '0;
        rd_idx     = '0;
        wr_idx     = '0;

        alu_eff = alu_valid && (alu_rd != '0);
        ld_eff  = ld_valid && ld_ready && (ld_rd != '0);

        for (int k = 0; k < int'(DEPTH); k++) begin
            rd_idx      = head_q + PTR_W'(k);
            ord_rd[k]   = ent_rd_q[rd_idx];
            ord_data[k] = ent_data_q[rd_idx];
            ord_v[k]    = valid_q[rd_idx];
            new_rd[k]   = '0;
            new_data[k] = '0;
        end

        if (alu_eff) begin
            wr_en_d = 1'b1;
            rd_d    = alu_rd;
            out_d   = alu_data;
        end else if (cnt_q != '0) begin
            wr_en_d = 1'b1;
            rd_d    = ord_rd[0];
            out_d   = ord_data[0];
            drain   = 1'b1;
        end else if (ld_eff) begin
            wr_en_d = 1'b1;
            rd_d    = ld_rd;
            out_d   = ld_data;
            bypass  = 1'b1;
        end
        enq = ld_eff && !bypass;

        // Keep surviving older entries in order; the same-cycle load is younger
        // than the ALU write, so it is appended after the squash.
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (ord_v[k] && !(drain && k == 0) && !(alu_eff && ord_rd[k] == alu_rd)) begin
                new_rd[new_cnt[PTR_W-1:0]]   = ord_rd[k];
                new_data[new_cnt[PTR_W-1:0]] = ord_data[k];
                new_cnt = new_cnt + CNT_W'(1);
            end
        end
        if (enq && new_cnt < CNT_W'(DEPTH)) begin
            new_rd[new_cnt[PTR_W-1:0]]   = ld_rd;
            new_data[new_cnt[PTR_W-1:0]] = ld_data;
            new_cnt = new_cnt + CNT_W'(1);
        end

        head_d = head_q + PTR_W'(drain);
        for (int k = 0; k < int'(DEPTH); k++) begin
            wr_idx             = head_d + PTR_W'(k);
            ent_rd_d[wr_idx]   = new_rd[k];
            ent_data_d[wr_idx] = new_data[k];
            valid_d[wr_idx]    = (CNT_W'(k) < new_cnt);
        end
        tail_d = head_d + new_cnt[PTR_W-1:0];
        cnt_d  = new_cnt;
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q <= 1'b0;
            rd_q    <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                ent_rd_q[k]   <= '0;
                ent_data_q[k] <= '0;
            end
        end else begin
            wr_en_q    <= wr_en_d;
            rd_q       <= rd_d;
            out_q      <= out_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ent_rd_q   <= ent_rd_d;
            ent_data_q <= ent_data_d;
        end
    end

    // Tail always sits pend_cnt entries past head
    a_tail_consistent: assert property (@(posedge clk) disable iff (!rst)
        tail_q == PTR_W'(head_q + cnt_q[PTR_W-1:0]));

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus random
// traffic, checked against a queue-based model of pending loads.
module tb_regfile_writeback;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } pend_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic [ADDR_W-1:0] rs = '0;
    logic [ADDR_W-1:0] rt = '0;
    logic              hazard_rs, hazard_rt, stall_req, wr_en;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] out_w;
    logic [$clog2(DEPTH):0] pend_cnt;

    regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rs(rs), .rt(rt), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
        .stall_req(stall_req), .wr_en(wr_en), .rd(rd), .out(out_w),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: pending loads in age order and the expected write in flight
    pend_t             m_pend[$];
    logic              m_wr = 1'b0;
    logic [ADDR_W-1:0] m_rd = '0;
    logic [DATA_W-1:0] m_out = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hazard(input logic [ADDR_W-1:0] a);
        logic h = 1'b0;
        if (a == '0) return 1'b0;
        foreach (m_pend[i]) if (m_pend[i].rd == a) h = 1'b1;
        if (m_wr && m_rd == a) h = 1'b1;
        return h;
    endfunction

    // One clock cycle: check registered/derived outputs, apply inputs, advance model
    task automatic step(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                        input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ld,
                        input logic [ADDR_W-1:0] a_rs, input logic [ADDR_W-1:0] a_rt);
        logic  acc, aeff, leff, bypassed;
        pend_t keep[$];
        @(negedge clk);
        check_eq("wr_en", 64'(wr_en), 64'(m_wr));
        if (m_wr) begin
            check_eq("rd", 64'(rd), 64'(m_rd));
            check_eq("out", 64'(out_w), 64'(m_out));
        end
        check_eq("pend_cnt", 64'(pend_cnt), 64'(m_pend.size()));
        check_eq("ld_ready", 64'(ld_ready), 64'(m_pend.size() < DEPTH));
        check_eq("stall_req", 64'(stall_req), 64'(m_pend.size() == DEPTH));
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_data = ld;
        rs = a_rs; rt = a_rt;
        #1;
        check_eq("hazard_rs", 64'(hazard_rs), 64'(m_hazard(a_rs)));
        check_eq("hazard_rt", 64'(hazard_rt), 64'(m_hazard(a_rt)));

        acc      = lv && (m_pend.size() < DEPTH);
        leff     = acc && (lrd != '0);
        aeff     = av && (ard != '0);
        bypassed = 1'b0;
        m_wr     = 1'b0;
        if (aeff) begin
            foreach (m_pend[i]) if (m_pend[i].rd != ard) keep.push_back(m_pend[i]);
            m_pend = keep;
            m_wr = 1'b1; m_rd = ard; m_out = ad;
        end else if (m_pend.size() > 0) begin
            pend_t h = m_pend.pop_front();
            m_wr = 1'b1; m_rd = h.rd; m_out = h.data;
        end else if (leff) begin
            m_wr = 1'b1; m_rd = lrd; m_out = ld;
            bypassed = 1'b1;
        end
        if (leff && !bypassed) m_pend.push_back('{rd: lrd, data: ld});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Single ALU write, then an ALU write to r0 that must be dropped
        step(1'b1, 5'd3, 32'hAAAA_AAAA, 1'b0, '0, '0, '0, '0);
        step(1'b1, 5'd0, 32'h1234_5678, 1'b0, '0, '0, '0, '0);
        idle(2);

        // Load deferral behind three ALU cycles, FIFO fills; then reset mid-traffic
        step(1'b1, 5'd1, 32'h100, 1'b1, 5'd5, 32'h11, '0, '0);
        step(1'b1, 5'd2, 32'h200, 1'b1, 5'd6, 32'h22, 5'd5, 5'd6);
        step(1'b1, 5'd4, 32'h300, 1'b0, '0, '0, 5'd5, 5'd0);
        @(negedge clk);
        check_eq("full_pend_cnt", 64'(pend_cnt), 64'(2));
        check_eq("full_stall", 64'(stall_req), 64'(1));
        rs = 5'd5; rt = 5'd6;
        alu_valid = 1'b0; ld_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("rst_wr_en", 64'(wr_en), 64'(0));
        check_eq("rst_rd", 64'(rd), 64'(0));
        check_eq("rst_out", 64'(out_w), 64'(0));
        check_eq("rst_pend_cnt", 64'(pend_cnt), 64'(0));
        check_eq("rst_ld_ready", 64'(ld_ready), 64'(1));
        check_eq("rst_stall", 64'(stall_req), 64'(0));
        check_eq("rst_hazard_rs", 64'(hazard_rs), 64'(0));
        check_eq("rst_hazard_rt", 64'(hazard_rt), 64'(0));
        m_pend.delete();
        m_wr = 1'b0; m_rd = '0; m_out = '0;
        @(negedge clk);
        rst = 1'b1;
        idle(3);

        // Deferral again, then ALU stops and rd=5, rd=6 drain back to back
        step(1'b1, 5'd1, 32'h100, 1'b1, 5'd5, 32'h11, '0, '0);
        step(1'b1, 5'd2, 32'h200, 1'b1, 5'd6, 32'h22, '0, '0);
        step(1'b1, 5'd4, 32'h300, 1'b0, '0, '0, '0, '0);
        idle(4);

        // Squash: pending rd=7 killed by ALU rd=7; same-cycle load survives
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h55, '0, '0);
        step(1'b1, 5'd7, 32'h99, 1'b0, '0, '0, 5'd7, '0);
        idle(2);
        step(1'b1, 5'd7, 32'h99, 1'b1, 5'd7, 32'h55, '0, '0);
        idle(3);

        // Hazard on pending rd=9 and its write in flight
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9, '0, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd9);

        // Random traffic with narrow register range to provoke squash, hazards, wrap
        for (int c = 0; c < 600; c++) begin
            int alu_pct = ((c / 40) % 2 == 1) ? 85 : 30;
            step(1'(($urandom % 100) < alu_pct), ADDR_W'($urandom_range(0, 7)), $urandom,
                 1'(($urandom % 100) < 60), ADDR_W'($urandom_range(0, 7)), $urandom,
                 ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
